// File: rtl/seq_gen_sched_if.sv
// seq_gen_sched_if: request/pattern inputs and serial/status outputs of the shared sequence generator
interface seq_gen_sched_if #(
    parameter int M  = 6,
    parameter int CW = 8
);
    logic          req0;
    logic [M-1:0]  pat0;
    logic [CW-1:0] rep0;
    logic          req1;
    logic [M-1:0]  pat1;
    logic [CW-1:0] rep1;
    logic          abort;
    logic          gnt0;
    logic          gnt1;
    logic          owner;
    logic          busy;
    logic          out;
    logic          out_valid;
    logic          done;
    logic          aborted;

    modport master (
        output req0, pat0, rep0, req1, pat1, rep1, abort,
        input  gnt0, gnt1, owner, busy, out, out_valid, done, aborted
    );

    modport slave (
        input  req0, pat0, rep0, req1, pat1, rep1, abort,
        output gnt0, gnt1, owner, busy, out, out_valid, done, aborted
    );
endinterface

// File: rtl/seq_gen_sched.sv
// seq_gen_sched: round-robin scheduler sharing one rotating pattern generator between two requesters
module seq_gen_sched #(
    parameter int M  = 6,
    parameter int CW = 8
) (
    input logic            clk,
    input logic            rst_n,
    seq_gen_sched_if.slave sgs
);
    localparam int BW = (M > 2) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t        r_state, w_next;
    logic [M-1:0]  r_q;
    logic [BW-1:0] r_bitcnt;
    logic [CW-1:0] r_repcnt;
    logic          r_owner, r_last_owner, r_gnt0, r_gnt1, r_aborted;
    logic          w_req, w_sel, w_last_bit, w_end;

    assign w_req      = sgs.req0 | sgs.req1;
    assign w_sel      = (sgs.req0 & sgs.req1) ? ~r_last_owner : sgs.req1;
    assign w_last_bit = r_bitcnt == BW'(M - 1);
    assign w_end      = sgs.abort | (w_last_bit & (r_repcnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_req ? PLAY : IDLE) :
                 (r_state == PLAY) ? (w_end ? DONE : PLAY) : IDLE;
    end

    // Pattern, repeat count and owner are captured only on the granting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q          <= '0;
            r_bitcnt     <= '0;
            r_repcnt     <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            if (r_state == IDLE && w_req) begin
                r_q       <= w_sel ? sgs.pat1 : sgs.pat0;
                r_repcnt  <= w_sel ? sgs.rep1 : sgs.rep0;
                r_bitcnt  <= '0;
                r_owner   <= w_sel;
                r_gnt0    <= ~w_sel;
                r_gnt1    <= w_sel;
                r_aborted <= 1'b0;
            end else if (r_state == PLAY) begin
                r_q       <= {r_q[M-2:0], r_q[M-1]};
                r_bitcnt  <= w_last_bit ? '0 : r_bitcnt + 1'b1;
                r_aborted <= sgs.abort;
                if (w_last_bit && r_repcnt != '0) r_repcnt <= r_repcnt - 1'b1;
                if (w_end) r_last_owner <= r_owner;
            end
        end
    end

    always_comb begin
        sgs.gnt0      = r_gnt0;
        sgs.gnt1      = r_gnt1;
        sgs.owner     = r_owner;
        sgs.busy      = r_state != IDLE;
        sgs.out_valid = r_state == PLAY;
        sgs.out       = (r_state == PLAY) & r_q[M-1];
        sgs.done      = r_state == DONE;
        sgs.aborted   = (r_state == DONE) & r_aborted;
    end
endmodule

// File: tb/tb_seq_gen_sched.sv
// tb_seq_gen_sched: directed checks of grant, playback, arbitration, abort and async reset
module tb_seq_gen_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    seq_gen_sched_if #(.M(6), .CW(8)) bus ();
    seq_gen_sched #(.M(6), .CW(8)) dut (.clk(clk), .rst_n(rst_n), .sgs(bus.slave));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {bus.gnt0, bus.gnt1, bus.owner, bus.busy, bus.out, bus.out_valid, bus.done, bus.aborted};
    endfunction

    // Entered in the first valid-bit cycle; returns in the IDLE cycle after DONE.
    task automatic play_chk(input string tag, input logic own, input logic [5:0] pat,
                            input int nbits, input int abort_at, input logic exp_ab, input logic hold);
        for (int i = 0; i < nbits; i++) begin
            chk({tag, " valid"}, bus.out_valid, 1'b1);
            chk({tag, " bit"}, bus.out, pat[5 - (i % 6)]);
            if (i == 0) begin
                chk({tag, " gnt"}, {bus.gnt0, bus.gnt1}, own ? 2'b01 : 2'b10);
                chk({tag, " owner"}, bus.owner, own);
                if (!hold) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end else begin
                chk({tag, " gnt pulse"}, {bus.gnt0, bus.gnt1}, 2'b00);
            end
            if (i == abort_at) bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
        end
        chk({tag, " done"}, {bus.done, bus.aborted, bus.out_valid, bus.busy}, {1'b1, exp_ab, 1'b0, 1'b1});
        tick();
        chk({tag, " idle"}, {bus.done, bus.out_valid, bus.busy}, 3'b000);
    endtask

    initial begin
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.abort = 1'b0;
        bus.pat0 = 6'b100111; bus.rep0 = 8'd0;
        bus.pat1 = 6'b010101; bus.rep1 = 8'd0;
        repeat (3) tick();
        chk("reset outs", outs(), 8'h00);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle after reset", outs(), 8'h00);

        bus.req0 = 1'b1;
        tick();
        play_chk("single", 1'b0, 6'b100111, 6, -1, 1'b0, 1'b0);

        bus.req0 = 1'b1; bus.pat0 = 6'b110000; bus.rep0 = 8'd2;
        tick();
        play_chk("repeat", 1'b0, 6'b110000, 18, -1, 1'b0, 1'b0);

        bus.req1 = 1'b1; bus.pat1 = 6'b101100; bus.rep1 = 8'd5;
        tick();
        bus.pat1 = 6'b000000;
        play_chk("abort", 1'b1, 6'b101100, 3, 2, 1'b1, 1'b0);

        bus.pat0 = 6'b100111; bus.rep0 = 8'd0;
        bus.pat1 = 6'b010101; bus.rep1 = 8'd0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();
        play_chk("rr0", 1'b0, 6'b100111, 6, -1, 1'b0, 1'b1);
        tick();
        play_chk("rr1", 1'b1, 6'b010101, 6, -1, 1'b0, 1'b1);
        tick();
        play_chk("rr2", 1'b0, 6'b100111, 6, -1, 1'b0, 1'b0);

        bus.req1 = 1'b1;
        tick();
        chk("rst gnt1", bus.gnt1, 1'b1);
        bus.req1 = 1'b0;
        tick();
        tick();
        chk("rst mid play valid", bus.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async reset outs", outs(), 8'h00);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post reset tie", {bus.gnt0, bus.gnt1, bus.owner}, 3'b100);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
